pattern_tx: RTL and testbench
=============================

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter PAT_W, default 6, pattern length in bits (2..16).
REQ-002 Parameter GAP_LEN, default 2, idle cycles inserted between repetitions (0..15).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rstn  input  1  reset; asynchronous, active-low.
REQ-005 Port start  input  1  request to transmit, sampled on rising edge in IDLE only.
REQ-006 Port pattern  input  PAT_W  pattern to serialize, MSB transmitted first.
REQ-007 Port repeat_cnt  input  4  number of additional repetitions (total transmissions = repeat_cnt+1).
REQ-008 Port abort  input  1  synchronous cancel of an active transmission.
REQ-009 Port x  output  1  serial data bit, directly drivable into a pattern detector x input.
REQ-010 Port x_valid  output  1  high while x carries a pattern bit.
REQ-011 Port busy  output  1  high while the FSM is not in IDLE.
REQ-012 Port done  output  1  single-cycle pulse after the final bit of the final repetition.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, GAP, DONE; encoding is registered, no latches.
REQ-014 IDLE: start=1 at an edge SHALL latch pattern and repeat_cnt and move to SHIFT; x=0, x_valid=0.
REQ-015 First pattern bit (pattern[PAT_W-1]) SHALL appear on x with x_valid=1 in the cycle immediately after the start edge (latency 1).
REQ-016 SHIFT SHALL emit one bit per cycle MSB→LSB for exactly PAT_W cycles using a bit counter.
REQ-017 After the LSB: if repetitions remain and GAP_LEN>0 go to GAP; if repetitions remain and GAP_LEN=0 go directly to SHIFT with the latched pattern MSB on the next cycle (back-to-back, no bubble); otherwise go to DONE.
REQ-018 GAP SHALL last exactly GAP_LEN cycles with x_valid=0 and x=0, then return to SHIFT.
REQ-019 DONE SHALL last one cycle with done=1, x=0, x_valid=0, then go to IDLE.
REQ-020 Repetition counter SHALL decrement once per completed pattern; repeat_cnt=0 gives one transmission, 15 gives sixteen.
REQ-021 start while busy SHALL be ignored; changes to pattern/repeat_cnt while busy SHALL NOT affect output.
REQ-022 abort=1 in SHIFT or GAP SHALL force IDLE at that edge, x=0, x_valid=0, no done pulse; abort has priority over all transitions.
REQ-023 abort in IDLE or DONE SHALL have no effect (DONE still pulses done); start and abort together in IDLE: start wins.
REQ-024 busy SHALL be 1 in SHIFT, GAP, DONE; start accepted in the cycle after DONE (IDLE).
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 rstn=0 SHALL immediately force IDLE, x=0, x_valid=0, busy=0, done=0, all counters and latched pattern to 0, regardless of clk.
REQ-027 Reset asserted mid-transmission SHALL discard the transmission; first start after rstn rises begins fresh.

Configuration
REQ-028 Macro PATTERN_TX_PRBS_GAP_EN: when defined, GAP cycles SHALL drive x from a 7-bit LFSR (x^7+x^6+1, seed 7'h01 at reset, advancing only in GAP), x_valid still 0; when undefined, GAP drives x=0 and no LFSR is built.

Verification
REQ-029 PAT_W=6, GAP_LEN=2, pattern=6'b110100, repeat_cnt=0, start 1 cycle -> x=1,1,0,1,0,0 with x_valid=1 cycles 1..6, done=1 at cycle 7, busy=0 at cycle 8; a pattern_detector_52 on x asserts y once.
REQ-030 pattern=6'b110100, repeat_cnt=2, GAP_LEN=0 -> 18 contiguous valid bits, done at cycle 19, detector fires 3 times.
REQ-031 repeat_cnt=1, GAP_LEN=3 -> 6 valid bits, 3 cycles x=0/x_valid=0 (LFSR bits if macro defined), 6 valid bits, done at cycle 16.
REQ-032 abort asserted at 4th SHIFT cycle -> IDLE next edge, x_valid=0, no done; new start 2 cycles later transmits full pattern.
REQ-033 rstn pulsed low mid-GAP between clock edges -> outputs zero immediately; start toggled during busy ignored; pattern changed during busy does not alter x.

Source files
------------

// File: rtl/pattern_tx.sv
// pattern_tx -- serializes a latched PAT_W-bit pattern MSB first, repeated
// repeat_cnt+1 times with GAP_LEN idle cycles between repetitions.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   start             begin a transmission (accepted in IDLE only)
//   pattern           pattern to send, MSB first
//   repeat_cnt        additional repetitions (total = repeat_cnt+1)
//   abort             cancel an active transmission (SHIFT/GAP only)
//   x, x_valid        serial bit and its qualifier
//   busy              FSM not in IDLE
//   done              one-cycle pulse after the last bit of the last repetition
//
// Optional feature macro: PATTERN_TX_PRBS_GAP_EN -- GAP cycles drive x from a
// 7-bit LFSR (x^7+x^6+1, seed 7'h01) instead of 0.
//
// All outputs are registered: each branch computes the values the outputs
// will carry in the state being entered.
module pattern_tx #(
  parameter int PAT_W   = 6,
  parameter int GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       repeat_cnt,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int             CW       = $clog2(PAT_W + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(PAT_W);
  localparam logic [3:0]     GAP_LAST = 4'(GAP_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_r;    // latched pattern, reloaded for each repetition
  logic [PAT_W-1:0] sh_r;     // remaining bits of the current repetition
  logic [3:0]       rep_r;    // repetitions still to send after the current one
  logic [CW-1:0]    bit_cnt;  // bits already placed on x in this repetition
  logic [3:0]       gap_cnt;  // gap cycles already placed on x
`ifdef PATTERN_TX_PRBS_GAP_EN
  logic [6:0]       lfsr;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      pat_r   <= '0;
      sh_r    <= '0;
      rep_r   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef PATTERN_TX_PRBS_GAP_EN
      lfsr    <= 7'h01;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // start beats a simultaneous abort here: abort only acts in SHIFT/GAP
          if (start) begin
            state   <= SHIFT;
            pat_r   <= pattern;
            rep_r   <= repeat_cnt;
            sh_r    <= {pattern[PAT_W-2:0], 1'b0};
            bit_cnt <= CW'(1);
            x       <= pattern[PAT_W-1];
            x_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end

        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end else if (bit_cnt != LAST_BIT) begin
            x       <= sh_r[PAT_W-1];
            sh_r    <= {sh_r[PAT_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + CW'(1);
          end else if (rep_r != 4'd0) begin
            rep_r <= rep_r - 4'd1;
            if (GAP_LEN > 0) begin
              state   <= GAP;
              gap_cnt <= 4'd1;
              x_valid <= 1'b0;
`ifdef PATTERN_TX_PRBS_GAP_EN
              x       <= lfsr[6];
              lfsr    <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
`else
              x       <= 1'b0;
`endif
            end else begin
              // back-to-back repetition: MSB follows the LSB with no bubble
              sh_r    <= {pat_r[PAT_W-2:0], 1'b0};
              bit_cnt <= CW'(1);
              x       <= pat_r[PAT_W-1];
            end
          end else begin
            state   <= DONE;
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b1;
          end
        end

        GAP: begin
          if (abort) begin
            state   <= IDLE;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end else if (gap_cnt == GAP_LAST) begin
            state   <= SHIFT;
            sh_r    <= {pat_r[PAT_W-2:0], 1'b0};
            bit_cnt <= CW'(1);
            x       <= pat_r[PAT_W-1];
            x_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
`ifdef PATTERN_TX_PRBS_GAP_EN
            x       <= lfsr[6];
            lfsr    <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
`else
            x       <= 1'b0;
`endif
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: three instances (GAP_LEN 2, 0, 3) share one stimulus.
// A transaction-level model turns each accepted start into a queue of expected
// output cycles; a per-cycle checker compares every instance against it.
module tb_pattern_tx;
  localparam int PW = 6;

  logic          clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic [3:0]    repeat_cnt = '0;
  logic [2:0]    x, xv, busy, done;

  int errs = 0, checks = 0;

  pattern_tx #(.PAT_W(PW), .GAP_LEN(2)) u_g2 (.clk(clk), .rstn(rstn), .start(start),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .abort(abort),
    .x(x[0]), .x_valid(xv[0]), .busy(busy[0]), .done(done[0]));
  pattern_tx #(.PAT_W(PW), .GAP_LEN(0)) u_g0 (.clk(clk), .rstn(rstn), .start(start),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .abort(abort),
    .x(x[1]), .x_valid(xv[1]), .busy(busy[1]), .done(done[1]));
  pattern_tx #(.PAT_W(PW), .GAP_LEN(3)) u_g3 (.clk(clk), .rstn(rstn), .start(start),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .abort(abort),
    .x(x[2]), .x_valid(xv[2]), .busy(busy[2]), .done(done[2]));

  always #5 clk = ~clk;

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic x; logic v; logic d; } item_t;
  item_t q [3][$];

  task automatic fill(input int i, input logic [PW-1:0] p, input int rep);
    for (int r = 0; r <= rep; r++) begin
      for (int b = PW - 1; b >= 0; b--) q[i].push_back('{x: p[b], v: 1'b1, d: 1'b0});
      if (r < rep)
        for (int g = 0; g < gap_of(i); g++) q[i].push_back('{x: 1'b0, v: 1'b0, d: 1'b0});
    end
    q[i].push_back('{x: 1'b0, v: 1'b0, d: 1'b1});
  endtask

  // queue front = what the outputs show this cycle; empty = IDLE
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) q[i].delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (q[i].size() == 0) begin
          if (start) fill(i, pattern, int'(repeat_cnt));
        end else if (abort && !q[i][0].d) begin
          q[i].delete();
        end else begin
          void'(q[i].pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      item_t e;
      e = (q[i].size() != 0) ? q[i][0] : item_t'(0);
`ifdef PATTERN_TX_PRBS_GAP_EN
      if (e.v || e.d || q[i].size() == 0)
`endif
      chk($sformatf("x[g%0d]", gap_of(i)), int'(x[i]), int'(e.x));
      chk($sformatf("x_valid[g%0d]", gap_of(i)), int'(xv[i]), int'(e.v));
      chk($sformatf("done[g%0d]", gap_of(i)), int'(done[i]), int'(e.d));
      chk($sformatf("busy[g%0d]", gap_of(i)), int'(busy[i]), int'(q[i].size() != 0));
    end
  end

  // ---------------- directed transaction runner ----------------
  // dc = cycle of done pulse (start edge = cycle 0), ic = first idle cycle,
  // vc = valid bits, hits = aligned 110100 windows in the valid-bit stream
  task automatic run_txn(input logic [PW-1:0] p, input int rep, input bit scramble,
                         output int dc[3], output int ic[3], output int vc[3], output int hits[3]);
    logic [5:0] win [3];
    bit fin;
    for (int i = 0; i < 3; i++) begin dc[i] = 0; ic[i] = 0; vc[i] = 0; hits[i] = 0; win[i] = '0; end
    @(negedge clk);
    pattern = p; repeat_cnt = 4'(rep); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fin = 1'b0;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (xv[i]) begin
          vc[i]++;
          win[i] = {win[i][4:0], x[i]};
          if (win[i] == 6'b110100) hits[i]++;
        end
        if (done[i] && dc[i] == 0) dc[i] = cyc;
        if (!busy[i] && ic[i] == 0) ic[i] = cyc;
      end
      if (busy == 3'b000) fin = 1'b1;
      else begin
        if (scramble) begin
          pattern = PW'($urandom);
          repeat_cnt = 4'($urandom);
          start = (busy == 3'b111) ? 1'($urandom) : 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("txn_timeout", int'(busy), 0);
  endtask

  typedef struct {
    logic [PW-1:0] p;
    int rep;
    int d2, d0, d3;
    int vc;
  } vec_t;

  vec_t tbl [6];
  int dc[3], ic[3], vc[3], hits[3];

  initial begin
    // done cycle = (rep+1)*6 + rep*gap + 1
    tbl[0] = '{6'b110100, 0,   7,  7,   7,  6};
    tbl[1] = '{6'b110100, 2,  23, 19,  25, 18};
    tbl[2] = '{6'b110100, 1,  15, 13,  16, 12};
    tbl[3] = '{6'b101011, 3,  31, 25,  34, 24};
    tbl[4] = '{6'b111111, 15, 127, 97, 142, 96};
    tbl[5] = '{6'b000001, 1,  15, 13,  16, 12};

    #1;
    chk("reset_x", int'(x), 0);
    chk("reset_xv", int'(xv), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // table: timing, counts and detector hits; odd rows scramble inputs while busy
    for (int t = 0; t < 6; t++) begin
      run_txn(tbl[t].p, tbl[t].rep, t[0], dc, ic, vc, hits);
      chk($sformatf("t%0d_done_g2", t), dc[0], tbl[t].d2);
      chk($sformatf("t%0d_done_g0", t), dc[1], tbl[t].d0);
      chk($sformatf("t%0d_done_g3", t), dc[2], tbl[t].d3);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t%0d_valid_g%0d", t, gap_of(i)), vc[i], tbl[t].vc);
        chk($sformatf("t%0d_idle_g%0d", t, gap_of(i)), ic[i], dc[i] + 1);
        if (tbl[t].p == 6'b110100)
          chk($sformatf("t%0d_hits_g%0d", t, gap_of(i)), hits[i], tbl[t].rep + 1);
      end
    end

    // abort at the 4th SHIFT cycle, restart 2 cycles later
    @(negedge clk);
    pattern = 6'b110100; repeat_cnt = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;           // cycle 1
    @(negedge clk); @(negedge clk); @(negedge clk);  // cycle 4
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_xv", int'(xv), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    run_txn(6'b110100, 0, 1'b0, dc, ic, vc, hits);
    chk("post_abort_valid", vc[0], 6);
    chk("post_abort_done", dc[0], 7);

    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", int'(busy), 7);
    for (int c = 0; c < 40 && busy != 3'b000; c++) @(negedge clk);
    chk("start_abort_drain", int'(busy), 0);

    // asynchronous reset mid-GAP (g2 is in its gap at cycles 7..8)
    pattern = 6'b110100; repeat_cnt = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 6; c++) @(negedge clk);      // cycle 7
    chk("gap_entered", int'({busy[0], xv[0]}), 2);
    #2 rstn = 1'b0;
    #1;
    chk("arst_x", int'(x), 0);
    chk("arst_xv", int'(xv), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    @(negedge clk); rstn = 1'b1;
    run_txn(6'b110100, 0, 1'b0, dc, ic, vc, hits);
    chk("post_rst_done", dc[2], 7);
    chk("post_rst_hits", hits[2], 1);

    // randomized traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      pattern = PW'($urandom);
      repeat_cnt = 4'($urandom_range(0, 3));
      abort = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 200 && busy != 3'b000; c++) @(negedge clk);
    chk("final_drain", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
